rect_loop_tile_scheduler: RTL and testbench

//  Sequences the rectangle-loop 2x2 core across a larger binary matrix held in a tile memory.
//  On start it walks every 2x2 tile in row-major order: read tile -> drive core -> wait core

---
 rtl/rect_loop_tile_scheduler.sv | 169 ++++++++++++++++
 tb/tb_rect_loop_tile_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_loop_tile_scheduler.sv
// Walks every 2x2 tile of a tile RAM through a rectangle-loop core and writes results back.
// Optional RECT_LOOP_SKIP_ZERO_EN: all-zero tiles bypass the core and write 0 directly.
module rect_loop_tile_scheduler #(
    parameter int TILE_ROWS = 4,
    parameter int TILE_COLS = 4,
    parameter int PARAM_W   = 12,
    parameter int CORE_LAT  = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [PARAM_W-1:0]                          param,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        rd_en,
    output logic [$clog2(TILE_ROWS*TILE_COLS)-1:0]      rd_addr,
    input  logic [3:0]                                  rd_data,
    output logic [PARAM_W-1:0]                          core_param,
    output logic [3:0]                                  core_m,
    input  logic [3:0]                                  core_m_out,
    output logic                                        wr_en,
    output logic [$clog2(TILE_ROWS*TILE_COLS)-1:0]      wr_addr,
    output logic [3:0]                                  wr_data,
    input  logic                                        wr_ready,
    output logic [$clog2(TILE_ROWS*TILE_COLS):0]        tile_cnt
);

    localparam int NT = TILE_ROWS * TILE_COLS;
    localparam int AW = $clog2(NT);
    localparam int LW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NT - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(CORE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RDWAIT,
        S_CORE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     idx;
    logic [LW-1:0]     lat_cnt;
    logic [PARAM_W-1:0] param_q;
    logic [3:0]        tile_q;
    logic              skip_tile;
    logic [3:0]        result;

`ifdef RECT_LOOP_SKIP_ZERO_EN
    logic              skip_q;

    assign skip_tile = (rd_data == 4'b0000);
    assign result    = skip_q ? 4'b0000 : core_m_out;
`else
    assign skip_tile = 1'b0;
    assign result    = core_m_out;
`endif

    assign core_param = param_q;
    assign core_m     = tile_q;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The core output is registered, so the result is consumed during WRITE,
    // where core_m is still held and core_m_out therefore stays stable under stall.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                rd_en     = 1'b1;
                rd_addr   = idx;
                state_nxt = S_RDWAIT;
            end
            S_RDWAIT: begin
                state_nxt = skip_tile ? S_WRITE : S_CORE;
            end
            S_CORE: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = idx;
                wr_data = result;
                if (wr_ready) begin
                    state_nxt = (idx == LAST_IDX) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            lat_cnt  <= '0;
            param_q  <= '0;
            tile_q   <= '0;
            tile_cnt <= '0;
`ifdef RECT_LOOP_SKIP_ZERO_EN
            skip_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        param_q  <= param;
                        idx      <= '0;
                        tile_cnt <= '0;
                    end
                end
                S_RDWAIT: begin
                    // A bypassed tile leaves core_m at its previous value.
                    if (!skip_tile) begin
                        tile_q <= rd_data;
                    end
                    lat_cnt <= '0;
`ifdef RECT_LOOP_SKIP_ZERO_EN
                    skip_q  <= skip_tile;
`endif
                end
                S_CORE: begin
                    if (lat_cnt != LAT_LAST) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        tile_cnt <= tile_cnt + 1'b1;
                        if (idx != LAST_IDX) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_loop_tile_scheduler.sv
// Randomized and directed bench for rect_loop_tile_scheduler with a tile RAM, an XOR core
// model and a queue-based reference of the expected result writes and run length.
module tb_rect_loop_tile_scheduler;

    localparam int NT  = 16;
    localparam int AW  = 4;
    localparam int LAT = 1;
`ifdef RECT_LOOP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [11:0]   param;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [3:0]    rd_data;
    logic [11:0]   core_param;
    logic [3:0]    core_m;
    logic [3:0]    core_m_out;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          wr_ready;
    logic [AW:0]   tile_cnt;

    always #5 clk = ~clk;

    rect_loop_tile_scheduler #(
        .TILE_ROWS(4),
        .TILE_COLS(4),
        .PARAM_W(12),
        .CORE_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .param(param),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .core_param(core_param), .core_m(core_m),
        .core_m_out(core_m_out), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .tile_cnt(tile_cnt)
    );

    // Tile RAM and core model
    logic [3:0] mem [NT];
    int         stall_tab [NT];
    logic [3:0] pipe [LAT];

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always @(posedge clk) begin
        pipe[0] <= core_m ^ core_param[3:0];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_m_out = pipe[LAT-1];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int         addr;
        logic [3:0] data;
    } wr_t;

    wr_t         exp_q [$];
    logic [11:0] exp_param;
    bit          armed = 1'b0;

    // Expected writes and run length straight from the tile-walk rules
    function automatic int build_model(input logic [11:0] p);
        int  cycles;
        wr_t e;
        cycles = 0;
        exp_q.delete();
        for (int k = 0; k < NT; k++) begin
            e.addr = k;
            if (SKIP && mem[k] == 4'h0) begin
                e.data = 4'h0;
                cycles += 3;
            end else begin
                e.data = mem[k] ^ p[3:0];
                cycles += LAT + 3;
            end
            cycles += stall_tab[k];
            exp_q.push_back(e);
        end
        return cycles;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Backpressure source: holds wr_ready low for stall_tab[addr] cycles of each write
    initial begin
        bit seen;
        int left;
        seen = 1'b0;
        left = 0;
        wr_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset || !wr_en) begin
                seen = 1'b0;
                wr_ready = 1'b1;
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    left = stall_tab[wr_addr];
                end
                if (left > 0) begin
                    wr_ready = 1'b0;
                    left--;
                end else begin
                    wr_ready = 1'b1;
                    seen = 1'b0;
                end
            end
        end
    end

    int         first_rd_cyc;
    int         first_rd_addr;
    int         done_cyc;
    int         done_cnt;

    initial begin
        bit         prev_pend;
        logic [3:0] prev_addr;
        logic [3:0] prev_data;
        wr_t        e;
        prev_pend = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_pend = 1'b0;
            end else begin
                chk("rd_wr_exclusive", {31'b0, rd_en & wr_en}, 0);
                if (prev_pend) begin
                    chk("stall_wr_en", {31'b0, wr_en}, 1);
                    chk("stall_wr_addr", {28'b0, wr_addr}, {28'b0, prev_addr});
                    chk("stall_wr_data", {28'b0, wr_data}, {28'b0, prev_data});
                    chk("stall_no_rd", {31'b0, rd_en}, 0);
                end
                if (armed && busy) chk("core_param", {20'b0, core_param}, {20'b0, exp_param});
                if (rd_en && first_rd_cyc < 0) begin
                    first_rd_cyc = cyc;
                    first_rd_addr = int'(rd_addr);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (wr_en && wr_ready) begin
                    chk("write_expected", {31'b0, exp_q.size() > 0}, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("wr_addr", {28'b0, wr_addr}, e.addr);
                        chk("wr_data", {28'b0, wr_data}, {28'b0, e.data});
                    end
                end
                prev_pend = wr_en && !wr_ready;
                prev_addr = wr_addr;
                prev_data = wr_data;
            end
        end
    end

    task automatic arm(input logic [11:0] p);
        exp_param = p;
        first_rd_cyc = -1;
        first_rd_addr = -1;
        done_cnt = 0;
        done_cyc = -1;
        armed = 1'b1;
    endtask

    // One full run; poke >= 0 re-pulses start with a new param while tile poke is read
    task automatic run(input string nm, input logic [11:0] p, input int poke, input int lit_cycles);
        int exp_cycles;
        bit got;
        exp_cycles = build_model(p);
        if (lit_cycles >= 0) chk({nm, "_model_cycles"}, exp_cycles, lit_cycles);
        arm(p);
        @(posedge clk); #1;
        param = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (poke >= 0 && rd_en && int'(rd_addr) == poke) begin
                start = 1'b1;
                param = 12'h005;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done_cnt > 0) got = 1'b1;
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, {31'b0, got}, 1);
        chk({nm, "_busy_after_done"}, {31'b0, busy}, 0);
        chk({nm, "_run_cycles"}, done_cyc - first_rd_cyc, exp_cycles);
        chk({nm, "_first_rd_addr"}, first_rd_addr, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_single_done"}, done_cnt, 1);
        chk({nm, "_tile_cnt"}, {27'b0, tile_cnt}, NT);
        chk({nm, "_all_written"}, exp_q.size(), 0);
        chk({nm, "_idle"}, {31'b0, busy}, 0);
        armed = 1'b0;
    endtask

    task automatic fill_linear();
        for (int k = 0; k < NT; k++) begin
            mem[k] = 4'(k);
            stall_tab[k] = 0;
        end
    endtask

    initial begin
        bit got;
        reset = 1'b1;
        start = 1'b0;
        param = '0;
        fill_linear();

        // Reset held, then released with start low
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_rd_en", {31'b0, rd_en}, 0);
        chk("rst_wr_en", {31'b0, wr_en}, 0);
        chk("rst_tile_cnt", {27'b0, tile_cnt}, 0);
        chk("rst_core_param", {20'b0, core_param}, 0);
        chk("rst_core_m", {28'b0, core_m}, 0);
        chk("rst_addrs", {24'b0, rd_addr, wr_addr}, 0);
        chk("rst_wr_data", {28'b0, wr_data}, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_no_rd", {31'b0, rd_en}, 0);
            chk("idle_not_busy", {31'b0, busy}, 0);
        end

        // Hand-computed pins of the reference model
        void'(build_model(12'h00A));
        chk("pin_tile3", {28'b0, exp_q[3].data}, 32'h9);
        chk("pin_tile15", {28'b0, exp_q[15].data}, 32'h5);

        run("basic", 12'h00A, -1, 64);

        stall_tab[3] = 5;
        run("stall", 12'h00A, -1, 69);
        stall_tab[3] = 0;

        run("restart_ignored", 12'h00A, 6, 64);

        // Reset during the write of tile 7
        stall_tab[7] = 2;
        void'(build_model(12'h00A));
        arm(12'h00A);
        @(posedge clk); #1;
        param = 12'h00A;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 4'd7) got = 1'b1;
        end
        chk("abort_reached_tile7", {31'b0, got}, 1);
        reset = 1'b1;
        #2;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_wr_en", {31'b0, wr_en}, 0);
        chk("abort_tile_cnt", {27'b0, tile_cnt}, 0);
        exp_q.delete();
        armed = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        stall_tab[7] = 0;
        run("after_abort", 12'h00A, -1, 64);

        // Zero tiles 0, 5, 9
        mem[5] = 4'h0;
        mem[9] = 4'h0;
        void'(build_model(12'h00A));
        chk("pin_zero_tile5", {28'b0, exp_q[5].data}, SKIP ? 32'h0 : 32'hA);
        run("zero_tiles", 12'h00A, -1, SKIP ? 61 : 64);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NT; k++) begin
                mem[k] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                stall_tab[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            end
            run("random", 12'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NT-1)) : -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
